// File: rtl/instruction_encoder.sv
`default_nettype none
// ============================================================================
// instruction_encoder: packs MIPS-32 R/I/J fields into words and streams them
// with byte addresses; optional format checking under INSTR_ENCODER_FMT_CHECK_EN.
// Revision: 1.0
// ============================================================================
module instruction_encoder #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       immediate,
  input  logic [25:0]       address,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-2:0] count;
  logic [ADDR_W-1:0] count_inc;
  logic              accept;
  logic              pop;
  logic              load;
  logic              last_pop;
  logic              illegal;
  logic [31:0]       encoded;

  // count holds words already popped, so it is also the index of the held word
  assign count_inc = {1'b0, count} + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign last_pop  = !(count_inc < DEPTH_W);
  assign out_valid = (state == ST_HOLD);
  assign done      = (state == ST_DONE);
  assign out_addr  = {count[ADDR_W-3:0], 2'b00};
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign load      = accept && !illegal;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_LOAD: in_ready = 1'b1;
      ST_HOLD: in_ready = out_ready && (count_inc < DEPTH_W);
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    encoded = 32'h0000_0000;
    case (fmt)
      2'b00:   encoded = {6'b000000, rs, rt, rd, shamt, funct};
      2'b01:   encoded = {opcode, rs, rt, immediate};
      2'b10:   encoded = {opcode, address};
      default: encoded = 32'h0000_0000;
    endcase
  end

`ifdef INSTR_ENCODER_FMT_CHECK_EN
  always_comb begin
    illegal = (fmt == 2'b11) ||
              ((fmt == 2'b00) && (opcode != 6'd0)) ||
              ((fmt == 2'b10) && (opcode != 6'd2) && (opcode != 6'd3));
  end

  logic err_q;
  always_ff @(posedge clk) begin
    if (reset || start) err_q <= 1'b0;
    else if (accept && illegal) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  // start has priority over everything, including a pop in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (start) state_nxt = ST_LOAD;
        else if (load) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (start) state_nxt = ST_LOAD;
        else if (pop && !load) state_nxt = last_pop ? ST_DONE : ST_LOAD;
      end
      ST_DONE: if (start) state_nxt = ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      out_word <= 32'h0000_0000;
    end else begin
      state <= state_nxt;
      if (start) count <= '0;
      else if (pop) count <= count_inc[ADDR_W-2:0];
      if (load && !start) out_word <= encoded;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_encoder.sv
`default_nettype none
// ============================================================================
// tb_instruction_encoder: directed self-checking bench, DEPTH=4.
// Revision: 1.0
// ============================================================================
module tb_instruction_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        fmt = 2'b00;
  logic [5:0]        opcode = 6'd0;
  logic [4:0]        rs = 5'd0;
  logic [4:0]        rt = 5'd0;
  logic [4:0]        rd = 5'd0;
  logic [4:0]        shamt = 5'd0;
  logic [5:0]        funct = 6'd0;
  logic [15:0]       immediate = 16'd0;
  logic [25:0]       address = 26'd0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic              done;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;

  instruction_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .immediate(immediate), .address(address),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_i(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                       input logic [15:0] imm);
    fmt = 2'b01; opcode = op; rs = s; rt = t; immediate = imm;
  endtask

  // Holds in_valid until the bundle is accepted, bounded by a cycle budget.
  task automatic drive_accept(input string tag);
    int n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      check({tag, "_accept_timeout"}, 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      tick();
      in_valid = 1'b0;
    end
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_word", out_word, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // R add, one-cycle latency
    pulse_start();
    check("load_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    fmt = 2'b00; opcode = 6'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd0; funct = 6'h20;
    drive_accept("radd");
    check("radd_valid", {31'd0, out_valid}, 32'd1);
    check("radd_word", out_word, 32'h0022_1820);
    check("radd_addr", out_addr, 32'h0);
    tick();
    check("radd_popped", {31'd0, out_valid}, 32'd0);
    check("radd_next_addr", out_addr, 32'h4);

    // back-to-back addi / lw
    pulse_start();
    set_i(6'h08, 5'd0, 5'd8, 16'd5);
    drive_accept("addi");
    check("addi_word", out_word, 32'h2008_0005);
    check("addi_addr", out_addr, 32'h0);
    set_i(6'h23, 5'd8, 5'd9, 16'd4);
    drive_accept("lw");
    check("lw_word", out_word, 32'h8D09_0004);
    check("lw_addr", out_addr, 32'h4);
    check("lw_valid", {31'd0, out_valid}, 32'd1);
    tick();

    // J with downstream stall
    out_ready = 1'b0;
    fmt = 2'b10; opcode = 6'd2; address = 26'h010_0000;
    drive_accept("j");
    check("j_word", out_word, 32'h0810_0000);
    check("j_addr", out_addr, 32'h8);
    address = 26'h3FF_FFFF; opcode = 6'h3F; fmt = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("j_hold_word", out_word, 32'h0810_0000);
      check("j_hold_addr", out_addr, 32'h8);
      check("j_hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("j_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    check("j_popped", {31'd0, out_valid}, 32'd0);

    // DEPTH=4 run, fifth bundle must be refused
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      set_i(6'h08, 5'd0, 5'd8, 16'(i));
      drive_accept("fill");
      check("fill_word", out_word, 32'h2008_0000 + 32'(i));
      check("fill_addr", out_addr, 32'(i * 4));
    end
    set_i(6'h08, 5'd0, 5'd8, 16'd4);
    in_valid = 1'b1;
    check("last_in_ready", {31'd0, in_ready}, 32'd0);
    check("last_done_early", {31'd0, done}, 32'd0);
    tick();
    check("done_set", {31'd0, done}, 32'd1);
    check("done_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("done_hold", {31'd0, done}, 32'd1);
    check("done_in_ready", {31'd0, in_ready}, 32'd0);

    // restart: pending fifth bundle goes to 0x0
    pulse_start();
    check("restart_done", {31'd0, done}, 32'd0);
    out_ready = 1'b0;
    drive_accept("restart");
    check("restart_word", out_word, 32'h2008_0004);
    check("restart_addr", out_addr, 32'h0);
    tick();

    // abort while holding: word discarded, next word at 0x0
    pulse_start();
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    set_i(6'h23, 5'd8, 5'd9, 16'd4);
    drive_accept("abort_next");
    check("abort_next_word", out_word, 32'h8D09_0004);
    check("abort_next_addr", out_addr, 32'h0);
    tick();

`ifdef INSTR_ENCODER_FMT_CHECK_EN
    fmt = 2'b00; opcode = 6'h08;
    drive_accept("illegal_r");
    check("illegal_valid", {31'd0, out_valid}, 32'd0);
    check("illegal_err", {31'd0, err}, 32'd1);
    check("illegal_addr", out_addr, 32'h4);
    pulse_start();
    check("err_cleared", {31'd0, err}, 32'd0);
`else
    fmt = 2'b11; opcode = 6'h3F; rs = 5'd31; immediate = 16'hFFFF; address = 26'h3FF_FFFF;
    drive_accept("reserved");
    check("reserved_valid", {31'd0, out_valid}, 32'd1);
    check("reserved_word", out_word, 32'h0);
    check("reserved_addr", out_addr, 32'h4);
    check("reserved_err", {31'd0, err}, 32'd0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_encoder.md
# instruction_encoder

Packs MIPS-32 instruction fields (R, I, J formats) into 32-bit instruction words and streams them, with sequential byte addresses, toward instruction-memory preload logic. It is the write-side counterpart of the field-extraction decoder in the fetch/decode path and is used by the program loader and self-checking benches. Input and output are valid/ready streams, and a one-entry output register allows one word per cycle. A word counter bounds the program length and drives a completion state.

## Interface
- DEPTH, 256: maximum number of words emitted per program; legal range 1..2^(ADDR_W-2).
- ADDR_W, 32: width of the output byte address.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; clears the word counter and begins a program
- in_valid  in  1  the field bundle is valid
- in_ready  out  1  the encoder accepts the bundle this cycle
- fmt  in  2  00 = R, 01 = I, 10 = J, 11 = reserved
- opcode  in  6  opcode field (I/J)
- rs, rt, rd, shamt  in  5 each  register and shift fields
- funct  in  6  function field (R)
- immediate  in  16  I-format immediate
- address  in  26  J-format target
- out_valid  out  1  out_word and out_addr are valid
- out_ready  in  1  the downstream side takes the word
- out_word  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address, equal to word index × 4
- done  out  1  DEPTH words have been emitted
- err  out  1  sticky illegal-format flag (only with the macro)

## Operation
- Encoding rules:
  - R: {6'b000000, rs, rt, rd, shamt, funct}. The opcode input is ignored.
  - I: {opcode, rs, rt, immediate}.
  - J: {opcode, address}.
  - Reserved fmt: 32'h00000000 (nop) when the macro is absent.
- FSM states:
  - IDLE: after reset. in_ready=0, out_valid=0. start → LOAD.
  - LOAD: output register empty. in_ready=1. An accept → HOLD.
  - HOLD: output register full. out_valid=1. in_ready = out_ready && (count+1 < DEPTH).
    - Pop without a new accept: go to LOAD, or to DONE if count reaches DEPTH.
    - Pop with a simultaneous accept: stay in HOLD with the new word loaded.
  - DONE: done=1, in_ready=0, out_valid=0. start → LOAD with count=0.
- Counter (count) holds the number of words popped. It increments on each out_valid && out_ready and is reset to 0 by reset or start. out_addr = {idx, 2'b00}, where idx is the index of the held word. The address never wraps, because DONE stops acceptance first.
- start while in LOAD or HOLD: aborts the program. The held word is discarded, count=0, and the next state is LOAD.
- start and a pop in the same cycle: start wins and no word is delivered.
- Input fields are sampled only on the accept cycle. Field changes while in_ready=0 have no effect.

## Timing
- Reset values: in_ready=0, out_valid=0, out_word=0, out_addr=0, done=0, err=0, state=IDLE, count=0.
- Latency: a bundle accepted at edge N appears on out_word with out_valid=1 after edge N, i.e. 1 cycle.
- Throughput: 1 word per cycle while out_ready=1.
- Output hold: out_word and out_addr stay stable while out_valid=1 and out_ready=0.
- Output register: registered and not combinational from inputs. in_ready is combinational from state, count and out_ready.
- done rises on the cycle after the DEPTH-th pop and holds until start or reset.

## Configuration
- INSTR_ENCODER_FMT_CHECK_EN
  - Defined: a bundle is illegal if fmt=11, if fmt=R with opcode≠0, or if fmt=J with opcode∉{2,3}.
    - An illegal bundle is accepted (handshake completes) but is dropped: no word and no count change.
    - err sets on the following edge and clears only on reset or start.
  - Undefined: no checking. err is tied to 0, and a reserved fmt emits a nop word.

## Test plan
- R add: fmt=00, rs=1, rt=2, rd=3, shamt=0, funct=0x20 → out_word=0x00221820, out_addr=0x0, 1-cycle latency.
- Back-to-back stream with out_ready=1:
  - addi (fmt=01, opcode=0x08, rs=0, rt=8, imm=5) → 0x20080005 @0x0.
  - lw (fmt=01, opcode=0x23, rs=8, rt=9, imm=4) → 0x8D090004 @0x4, on consecutive cycles.
- J: fmt=10, opcode=2, address=0x0100000 → 0x08100000.
  - Hold out_ready=0 for 3 cycles → word and address stable, in_ready=0.
- DEPTH=4, feed 5 bundles → addresses 0x0–0xC emitted, done=1 after the 4th pop, 5th bundle never accepted.
  - start → count=0, next word at 0x0.
- start pulse while in HOLD with out_ready=0 → held word discarded, no pop, next word at 0x0.
- Macro defined: fmt=00 with opcode=0x08 → no out_valid, err=1 next cycle, count unchanged.
  - Macro undefined, fmt=11 → out_word=0x00000000.
